// File: rtl/mem_stall_ctrl_pkg.sv
// mem_stall_ctrl_pkg: opcodes, funct3 encodings, FSM states and access-size helpers
package mem_stall_ctrl_pkg;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    typedef enum logic [2:0] {LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101} load_f3_e;
    typedef enum logic [2:0] {SB = 3'b000, SH = 3'b001, SW = 3'b010} store_f3_e;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
    // funct3[1:0] picks the size; every unused encoding falls back to a word
    function automatic size_e size_of(input logic [2:0] f3);
        return f3[1:0] == SB[1:0] ? SZ_B : f3[1:0] == SH[1:0] ? SZ_H : SZ_W;
    endfunction
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        return size_of(f3) == SZ_H ? lane[0] : size_of(f3) == SZ_W ? |lane : 1'b0;
    endfunction
endpackage

// File: rtl/mem_stall_ctrl_if.sv
// mem_stall_ctrl_if: L1 D-cache request/response channel
interface mem_stall_ctrl_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [3:0]      req_be;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    modport master (output req_valid, req_we, req_addr, req_wdata, req_be,
                    input  req_ready, resp_valid, resp_rdata);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_be,
                    output req_ready, resp_valid, resp_rdata);
endinterface

// File: rtl/mem_stall_ctrl_ls_align.sv
// ls_align: store lane replication and strobes, load lane extraction and extension
module ls_align
    import mem_stall_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] st_data,
    output logic [XLEN-1:0] ld_data
);
    size_e           sz;
    logic [XLEN-1:0] sh;
    // unsigned variants have funct3[2] set, which suppresses sign fill
    always_comb begin
        sz      = size_of(funct3);
        sh      = rdata >> {lane, 3'b000};
        be      = sz == SZ_B ? 4'b0001 << lane : sz == SZ_H ? 4'b0011 << lane : 4'b1111;
        st_data = sz == SZ_B ? {4{wdata[7:0]}} : sz == SZ_H ? {2{wdata[15:0]}} : wdata;
        ld_data = sz == SZ_B ? {{24{~funct3[2] & sh[7]}}, sh[7:0]} :
                  sz == SZ_H ? {{16{~funct3[2] & sh[15]}}, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: MEM-stage cache access sequencer with stall request and stall counter
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      inst_mem_i,
    input  logic [XLEN-1:0]  addr_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic             flush_mem_i,
    mem_stall_ctrl_if.master dc,
    output logic             stall_o,
    output logic [XLEN-1:0]  ld_data_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    state_e          state;
    logic [2:0]      f3_q;
    logic [1:0]      lane_q;
    logic            go, mis;
    logic [2:0]      al_f3;
    logic [1:0]      al_lane;
    logic [3:0]      be;
    logic [XLEN-1:0] st_data, ld_ext;
    assign go      = (inst_mem_i[6:0] == OP_LOAD || inst_mem_i[6:0] == OP_STORE) && !flush_mem_i;
    assign mis     = misaligned(inst_mem_i[14:12], addr_i[1:0]);
    assign stall_o = state == REQ || state == WAIT || (state == IDLE && go && !mis);
    // the aligner sees the incoming instruction while idle and the latched access afterwards
    assign al_f3   = state == IDLE ? inst_mem_i[14:12] : f3_q;
    assign al_lane = state == IDLE ? addr_i[1:0] : lane_q;
    ls_align #(.XLEN(XLEN)) u_align (
        .funct3  (al_f3),
        .lane    (al_lane),
        .wdata   (wdata_i),
        .rdata   (dc.resp_rdata),
        .be      (be),
        .st_data (st_data),
        .ld_data (ld_ext)
    );
    // access sequencer; request payload is latched on issue so it stays stable until accepted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            dc.req_valid <= 1'b0;
            dc.req_we    <= 1'b0;
            dc.req_addr  <= '0;
            dc.req_wdata <= '0;
            dc.req_be    <= '0;
            f3_q         <= '0;
            lane_q       <= '0;
            ld_data_o    <= '0;
            misalign_o   <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    if (mis) begin
                        state      <= DONE;
                        misalign_o <= 1'b1;
                    end else begin
                        state        <= REQ;
                        dc.req_valid <= 1'b1;
                        dc.req_we    <= inst_mem_i[6:0] == OP_STORE;
                        dc.req_addr  <= {addr_i[XLEN-1:2], 2'b00};
                        dc.req_wdata <= st_data;
                        dc.req_be    <= be;
                        f3_q         <= inst_mem_i[14:12];
                        lane_q       <= addr_i[1:0];
                    end
                end
                REQ: if (dc.req_ready) begin
                    dc.req_valid <= 1'b0;
                    state        <= WAIT;
                end
                WAIT: if (dc.resp_valid) begin
                    if (!dc.req_we) ld_data_o <= ld_ext;
                    state <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
    // saturating count of stalled cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_cnt_o <= '0;
        else if (stall_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: directed scoreboard bench for mem_stall_ctrl
module tb_mem_stall_ctrl;
    import mem_stall_ctrl_pkg::*;
    localparam int K_REQ = 0, K_MIS = 1, K_DONE = 2;
    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_st;
        logic [31:0] ld;
        logic        chk_ld;
        int          run;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] inst_mem_i = '0, addr_i = '0, wdata_i = '0;
    logic        flush_mem_i = 1'b0;
    logic        stall_o, misalign_o;
    logic [31:0] ld_data_o, stall_cnt_o;

    mem_stall_ctrl_if #(.XLEN(32)) dc ();

    mem_stall_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .inst_mem_i  (inst_mem_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .flush_mem_i (flush_mem_i),
        .dc          (dc),
        .stall_o     (stall_o),
        .ld_data_o   (ld_data_o),
        .misalign_o  (misalign_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          checks = 0, errors = 0;
    logic [31:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    function automatic logic [31:0] inst(input logic [6:0] op, input logic [2:0] f3);
        return {17'b0, f3, 5'b0, op};
    endfunction

    // monitor: compares every DUT-presented event against the head of the scoreboard
    exp_t e;
    int   run = 0;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        if (dc.req_valid) begin
            if (q.size() == 0 || q[0].kind != K_REQ) miss("unexpected_request");
            else begin
                chk("req_we", {31'b0, dc.req_we}, {31'b0, q[0].we});
                chk("req_addr", dc.req_addr, q[0].addr);
                if (q[0].chk_st) begin
                    chk("req_be", {28'b0, dc.req_be}, {28'b0, q[0].be});
                    chk("req_wdata", dc.req_wdata, q[0].wdata);
                end
                if (dc.req_ready) e = q.pop_front();
            end
        end
        if (misalign_o) begin
            if (q.size() == 0 || q[0].kind != K_MIS) miss("unexpected_misalign");
            else begin
                e = q.pop_front();
                chk("mis_stall", {31'b0, stall_o}, 32'd0);
                chk("mis_req_valid", {31'b0, dc.req_valid}, 32'd0);
                chk("mis_stall_run", run, e.run);
            end
        end
        if (prev_stall && !stall_o) begin
            if (q.size() == 0 || q[0].kind != K_DONE) miss("unexpected_stall_end");
            else begin
                e = q.pop_front();
                chk("stall_run", run, e.run);
                chk("stall_cnt", stall_cnt_o, e.cnt);
                if (e.chk_ld) chk("ld_data", ld_data_o, e.ld);
            end
        end
        run <= stall_o ? run + 1 : 0;
        prev_stall <= stall_o;
    end

    // one aligned access: nr cycles of ready low (with a stray response), then a 1-cycle response
    task automatic access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] eld, input int nr);
        exp_cnt += nr + 3;
        q.push_back('{kind: K_REQ, we: op == OP_STORE, addr: {a[31:2], 2'b00}, be: ebe, wdata: ewd,
                      chk_st: op == OP_STORE, ld: 0, chk_ld: 0, run: 0, cnt: 0});
        q.push_back('{kind: K_DONE, we: 0, addr: 0, be: 0, wdata: 0, chk_st: 0, ld: eld,
                      chk_ld: op == OP_LOAD, run: nr + 3, cnt: exp_cnt});
        #1;
        inst_mem_i = inst(op, f3);
        addr_i = a;
        wdata_i = wd;
        dc.req_ready = nr == 0;
        if (nr > 0) begin
            dc.resp_valid = 1'b1;
            dc.resp_rdata = 32'h5555AAAA;
        end
        @(posedge clk);
        #1 inst_mem_i = '0;
        repeat (nr) @(posedge clk);
        #1;
        dc.req_ready = 1'b1;
        dc.resp_valid = 1'b0;
        @(posedge clk);
        #1;
        dc.req_ready = 1'b0;
        dc.resp_valid = 1'b1;
        dc.resp_rdata = rd;
        @(posedge clk);
        #1 dc.resp_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic misaligned_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
        q.push_back('{kind: K_MIS, we: 0, addr: 0, be: 0, wdata: 0, chk_st: 0, ld: 0, chk_ld: 0,
                      run: 0, cnt: 0});
        #1;
        inst_mem_i = inst(op, f3);
        addr_i = a;
        #1 chk("mis_idle_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1 inst_mem_i = '0;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dc.req_ready = 1'b0;
        dc.resp_valid = 1'b0;
        dc.resp_rdata = '0;
        #12;
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_req_valid", {31'b0, dc.req_valid}, 32'd0);
        chk("rst_req_we", {31'b0, dc.req_we}, 32'd0);
        chk("rst_req_addr", dc.req_addr, 32'd0);
        chk("rst_req_wdata", dc.req_wdata, 32'd0);
        chk("rst_req_be", {28'b0, dc.req_be}, 32'd0);
        chk("rst_ld_data", ld_data_o, 32'd0);
        chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        access(OP_LOAD,  3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 4'hF,    32'h0,        32'hDEADBEEF, 0);
        access(OP_LOAD,  3'b000, 32'h103, 32'h0,        32'h80112233, 4'h0,    32'h0,        32'hFFFFFF80, 2);
        access(OP_LOAD,  3'b100, 32'h103, 32'h0,        32'h80112233, 4'h0,    32'h0,        32'h00000080, 0);
        access(OP_STORE, 3'b001, 32'h102, 32'h0000ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0,        5);
        access(OP_STORE, 3'b000, 32'h101, 32'h12345677, 32'h0,        4'b0010, 32'h77777777, 32'h0,        0);
        access(OP_STORE, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0,        4'hF,    32'hCAFEF00D, 32'h0,        1);
        access(OP_LOAD,  3'b001, 32'h102, 32'h0,        32'h80011234, 4'h0,    32'h0,        32'hFFFF8001, 0);
        access(OP_LOAD,  3'b101, 32'h100, 32'h0,        32'h1234F00D, 4'h0,    32'h0,        32'h0000F00D, 0);
        access(OP_LOAD,  3'b110, 32'h108, 32'h0,        32'h01020304, 4'h0,    32'h0,        32'h01020304, 0);
        misaligned_access(OP_LOAD, 3'b010, 32'h102);
        misaligned_access(OP_STORE, 3'b001, 32'h101);
        #1;
        inst_mem_i = inst(OP_LOAD, 3'b010);
        addr_i = 32'h100;
        flush_mem_i = 1'b1;
        #1 chk("flush_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        inst_mem_i = '0;
        flush_mem_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("flush_req_valid", {31'b0, dc.req_valid}, 32'd0);
        exp_cnt = '0;
        q.push_back('{kind: K_REQ, we: 0, addr: 32'h100, be: 0, wdata: 0, chk_st: 0, ld: 0, chk_ld: 0,
                      run: 0, cnt: 0});
        q.push_back('{kind: K_DONE, we: 0, addr: 0, be: 0, wdata: 0, chk_st: 0, ld: 0, chk_ld: 1,
                      run: 2, cnt: 0});
        @(posedge clk);
        #1;
        inst_mem_i = inst(OP_LOAD, 3'b010);
        addr_i = 32'h100;
        dc.req_ready = 1'b1;
        @(posedge clk);
        #1 inst_mem_i = '0;
        @(posedge clk);
        #1;
        dc.req_ready = 1'b0;
        rst_i = 1'b1;
        dc.resp_valid = 1'b1;
        dc.resp_rdata = 32'hFFFFFFFF;
        #1;
        chk("wait_rst_stall", {31'b0, stall_o}, 32'd0);
        chk("wait_rst_req_valid", {31'b0, dc.req_valid}, 32'd0);
        chk("wait_rst_ld_data", ld_data_o, 32'd0);
        chk("wait_rst_stall_cnt", stall_cnt_o, 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 dc.resp_valid = 1'b0;
        chk("late_resp_ld_data", ld_data_o, 32'd0);
        chk("late_resp_stall", {31'b0, stall_o}, 32'd0);
        chk("late_resp_stall_cnt", stall_cnt_o, exp_cnt);
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
